// File: rtl/aq_spsram_ctrl_if.sv
// rtl/aq_spsram_ctrl_if.sv - request/response channel between initiator logic and the SRAM bank controller
interface aq_spsram_ctrl_if #(
  parameter int AW = 13
);
  logic          req_vld;
  logic          req_rdy;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_wmask;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [31:0]   rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );
endinterface

// File: rtl/aq_spsram_ctrl.sv
// rtl/aq_spsram_ctrl.sv - word-interleaved 2048x32 SRAM bank controller with zero-fill init and read response FIFO
module aq_spsram_ctrl #(
  parameter int N       = 4,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  aq_spsram_ctrl_if.slave   bus,
  output logic              init_done,
  output logic [N*11-1:0]   sram_a,
  output logic [N-1:0]      sram_cen,
  output logic [N-1:0]      sram_clk,
  output logic [N*32-1:0]   sram_d,
  output logic [N-1:0]      sram_gwen,
  output logic [N*32-1:0]   sram_wen,
  input  logic [N*32-1:0]   sram_q
);

  localparam int AW = 11 + $clog2(N);
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [10:0]   r_row_cnt;
  logic          r_init_done;
  logic          r_rd_inflight;
  logic [BW-1:0] r_rd_bank;
  logic [31:0]   r_fifo [2];
  logic          r_fifo_wp;
  logic          r_fifo_rp;
  logic [1:0]    r_fifo_cnt;

  logic [BW-1:0] w_bank;
  logic [10:0]   w_row;
  logic [31:0]   w_q;
  logic          w_run;
  logic          w_pop;
  logic          w_fifo_pop;
  logic          w_push;
  logic [2:0]    w_occ;
  logic          w_acc;
  logic          w_rd_acc;

  // Low-order interleave: bank from the LSBs, row from the top 11 bits
  if (N > 1) begin : g_bank_sel
    assign w_bank = bus.req_addr[BW-1:0];
  end else begin : g_bank_one
    assign w_bank = '0;
  end
  assign w_row = bus.req_addr[AW-1:AW-11];

  assign sram_clk  = {N{forever_cpuclk}};
  assign init_done = r_init_done;

  // Reset is folded in so strobes and ready stay idle while cpurst_b is low
  assign w_run = (r_state == ST_RUN) & cpurst_b;

  assign w_q = sram_q[32*int'(r_rd_bank) +: 32];

  // Response side: FIFO head first, otherwise bypass the in-flight SRAM data
  assign bus.rsp_vld   = (r_fifo_cnt != 2'd0) | r_rd_inflight;
  assign bus.rsp_rdata = (r_fifo_cnt != 2'd0) ? r_fifo[r_fifo_rp] :
                         (r_rd_inflight ? w_q : 32'd0);

  assign w_pop      = bus.rsp_vld & bus.rsp_rdy;
  assign w_fifo_pop = w_pop & (r_fifo_cnt != 2'd0);
  // In-flight data is queued unless it leaves directly through the bypass
  assign w_push     = r_rd_inflight & ~((r_fifo_cnt == 2'd0) & bus.rsp_rdy);

  // Outstanding read slots after this cycle's pop; a read needs a free one
  assign w_occ       = {1'b0, r_fifo_cnt} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
  assign bus.req_rdy = w_run & (bus.req_wr | (w_occ < 3'd2));
  assign w_acc       = bus.req_vld & bus.req_rdy;
  assign w_rd_acc    = w_acc & ~bus.req_wr;

  // FSM state register and init completion flag
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state     <= INIT_EN ? ST_INIT : ST_RUN;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (w_state_nxt == ST_RUN);
    end
  end

  // Next state and per-bank SRAM strobes
  always_comb begin
    w_state_nxt = r_state;
    sram_cen    = '1;
    sram_gwen   = '1;
    sram_wen    = '1;
    sram_a      = '0;
    sram_d      = '0;
    case (r_state)
      ST_INIT: begin
        if (r_row_cnt == 11'd2047) w_state_nxt = ST_RUN;
        if (cpurst_b) begin
          sram_cen  = '0;
          sram_gwen = '0;
          sram_wen  = '0;
          sram_a    = {N{r_row_cnt}};
        end
      end
      ST_RUN: begin
        for (int b = 0; b < N; b++) begin
          if (w_acc && (int'(w_bank) == b)) begin
            sram_cen[b]          = 1'b0;
            sram_a[b*11 +: 11]   = w_row;
            if (bus.req_wr) begin
              sram_gwen[b]       = 1'b0;
              sram_d[b*32 +: 32] = bus.req_wdata;
              for (int by = 0; by < 4; by++) begin
                sram_wen[b*32 + by*8 +: 8] = {8{~bus.req_wmask[by]}};
              end
            end
          end
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Zero-fill row counter, advances every INIT cycle
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_row_cnt <= 11'd0;
    end else if (r_state == ST_INIT) begin
      r_row_cnt <= r_row_cnt + 11'd1;
    end
  end

  // Track the read accepted last cycle so its Q can be steered next cycle
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rd_inflight <= 1'b0;
      r_rd_bank     <= '0;
    end else begin
      r_rd_inflight <= w_rd_acc;
      if (w_rd_acc) r_rd_bank <= w_bank;
    end
  end

  // Two-entry response FIFO; push and pop together leave the count unchanged
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_fifo[0]  <= 32'd0;
      r_fifo[1]  <= 32'd0;
      r_fifo_wp  <= 1'b0;
      r_fifo_rp  <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_fifo_wp] <= w_q;
        r_fifo_wp         <= ~r_fifo_wp;
      end
      if (w_fifo_pop) r_fifo_rp <= ~r_fifo_rp;
      r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_fifo_pop};
    end
  end

endmodule
